// File: rtl/cholesky_pkg.sv
// Shared widths and state encoding for the Cholesky diagonal-radical path.
package cholesky_pkg;

    localparam int unsigned N_MAX  = 32;
    localparam int unsigned CNT_W  = $clog2(N_MAX + 1);
    localparam int unsigned ACC_W  = 44;
    localparam int unsigned RAD_W  = 36;
    localparam int unsigned L_W    = 27;
    localparam int unsigned FRAC   = 16;
    localparam int unsigned PROD_W = 2 * L_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SUB   = 3'd3,
        ST_OUT   = 3'd4
    } diag_state_t;

endpackage

// File: rtl/diag_square_pipe.sv
// Two-stage signed squarer: stage 1 holds L, stage 2 holds the Q22.32 square.
// pipe_empty means stage 1 is empty: any stage-2 product is absorbed on the next edge.
module diag_square_pipe
    import cholesky_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [L_W-1:0]    in_data,
    output logic              prod_valid,
    output logic [PROD_W-1:0] prod,
    output logic              pipe_empty
);

    logic                     s1_valid_q, s1_valid_d;
    logic [L_W-1:0]           s1_data_q, s1_data_d;
    logic                     prod_valid_q, prod_valid_d;
    logic [PROD_W-1:0]        prod_q, prod_d;
    logic                     pipe_empty_q, pipe_empty_d;
    logic signed [PROD_W-1:0] s1_ext;

    always_comb begin
        s1_valid_d   = in_valid;
        s1_data_d    = in_valid ? in_data : s1_data_q;
        s1_ext       = {{(PROD_W - L_W){s1_data_q[L_W-1]}}, s1_data_q};
        prod_valid_d = s1_valid_q;
        prod_d       = s1_valid_q ? PROD_W'(s1_ext * s1_ext) : prod_q;
        pipe_empty_d = !in_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            prod_valid_q <= 1'b0;
            prod_q       <= '0;
            pipe_empty_q <= 1'b1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            prod_valid_q <= prod_valid_d;
            prod_q       <= prod_d;
            pipe_empty_q <= pipe_empty_d;
        end
    end

    assign prod_valid = prod_valid_q;
    assign prod       = prod_q;
    assign pipe_empty = pipe_empty_q;

endmodule

// File: rtl/diag_radical_acc.sv
// Computes a_jj - sum(L_jk^2) for one Cholesky column and hands it to the sqrt stage.
// Define DIAG_RADICAL_CLAMP_EN to clamp negative radicals to zero and flag them.
module diag_radical_acc
    import cholesky_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RAD_W-1:0] diag_in,
    input  logic [CNT_W-1:0] k_len,
    input  logic             l_valid,
    input  logic [L_W-1:0]   l_data,
    output logic             l_ready,
    output logic             radical_valid,
    output logic [RAD_W-1:0] radical,
    input  logic             radical_ready,
    output logic             busy,
    output logic             clamp
);

    localparam int unsigned DIFF_W = ACC_W + 1;

    diag_state_t       state_q, state_d;
    logic [RAD_W-1:0]  diag_q, diag_d;
    logic [CNT_W-1:0]  klen_q, klen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [RAD_W-1:0]  radical_q, radical_d;
    logic              clamp_q, clamp_d;
    logic              radical_valid_q, radical_valid_d;
    logic              l_ready_q, l_ready_d;
    logic              busy_q, busy_d;

    logic              l_accept_c;
    logic [CNT_W-1:0]  klen_eff_c;
    logic [DIFF_W-1:0] diff_c;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              pipe_empty;

    assign l_accept_c = l_valid && l_ready_q;

    diag_square_pipe u_pipe (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (l_accept_c),
        .in_data    (l_data),
        .prod_valid (prod_valid),
        .prod       (prod),
        .pipe_empty (pipe_empty)
    );

    always_comb begin
        klen_eff_c = (k_len > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : k_len;
        diff_c     = DIFF_W'(diag_q) - DIFF_W'(acc_q);
    end

    // Next-state and datapath; squares are always >= 0 so the shift is a floor.
    always_comb begin
        state_d         = state_q;
        diag_d          = diag_q;
        klen_d          = klen_q;
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        radical_d       = radical_q;
        clamp_d         = clamp_q;
        radical_valid_d = radical_valid_q;

        if (prod_valid) begin
            acc_d = acc_q + ACC_W'(prod >> FRAC);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    diag_d  = diag_in;
                    klen_d  = klen_eff_c;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (klen_eff_c == '0) ? ST_SUB : ST_ACC;
                end
            end
            ST_ACC: begin
                if (l_accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == klen_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
`ifdef DIAG_RADICAL_CLAMP_EN
                if (diff_c[DIFF_W-1]) begin
                    radical_d = '0;
                    clamp_d   = 1'b1;
                end else begin
                    radical_d = RAD_W'(diff_c);
                    clamp_d   = 1'b0;
                end
`else
                radical_d = RAD_W'(diff_c);
                clamp_d   = 1'b0;
`endif
                radical_valid_d = 1'b1;
                state_d         = ST_OUT;
            end
            ST_OUT: begin
                if (radical_ready) begin
                    radical_valid_d = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        l_ready_d = (state_d == ST_ACC);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            diag_q          <= '0;
            klen_q          <= '0;
            cnt_q           <= '0;
            acc_q           <= '0;
            radical_q       <= '0;
            clamp_q         <= 1'b0;
            radical_valid_q <= 1'b0;
            l_ready_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            diag_q          <= diag_d;
            klen_q          <= klen_d;
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            radical_q       <= radical_d;
            clamp_q         <= clamp_d;
            radical_valid_q <= radical_valid_d;
            l_ready_q       <= l_ready_d;
            busy_q          <= busy_d;
        end
    end

    assign l_ready       = l_ready_q;
    assign busy          = busy_q;
    assign radical_valid = radical_valid_q;
    assign radical       = radical_q;
    assign clamp         = clamp_q;

endmodule

// File: tb/tb_diag_radical_acc.sv
// Self-checking bench for diag_radical_acc against an arithmetic reference model.
module tb_diag_radical_acc;
    import cholesky_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [RAD_W-1:0] diag_in;
    logic [CNT_W-1:0] k_len;
    logic             l_valid;
    logic [L_W-1:0]   l_data;
    logic             l_ready;
    logic             radical_valid;
    logic [RAD_W-1:0] radical;
    logic             radical_ready;
    logic             busy;
    logic             clamp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    diag_radical_acc dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .diag_in       (diag_in),
        .k_len         (k_len),
        .l_valid       (l_valid),
        .l_data        (l_data),
        .l_ready       (l_ready),
        .radical_valid (radical_valid),
        .radical       (radical),
        .radical_ready (radical_ready),
        .busy          (busy),
        .clamp         (clamp)
    );

    // Reference: plain integer arithmetic on real-valued fixed point.
    function automatic void model(input logic [RAD_W-1:0] diag, input int k,
                                  input logic [L_W-1:0] ls[$],
                                  output logic [RAD_W-1:0] rad, output logic c);
        longint sum = 0;
        longint d;
        longint v;
        int n = (k > 32) ? 32 : k;
        for (int i = 0; i < n; i++) begin
            v = longint'($signed(ls[i]));
            sum += (v * v) / 65536;
        end
        d = 0;
        d[RAD_W-1:0] = diag;
        d = d - sum;
`ifdef DIAG_RADICAL_CLAMP_EN
        if (d < 0) begin
            rad = '0;
            c   = 1'b1;
        end else begin
            rad = RAD_W'(d);
            c   = 1'b0;
        end
`else
        rad = RAD_W'(d);
        c   = 1'b0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [RAD_W-1:0] d, input int k);
        start   = 1'b1;
        diag_in = d;
        k_len   = CNT_W'(k);
        tick();
        start   = 1'b0;
    endtask

    // Returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [L_W-1:0] v, output bit ok);
        int guard = 0;
        l_valid = 1'b1;
        l_data  = v;
        while (!l_ready && guard < 100) begin
            tick();
            guard++;
        end
        ok = l_ready;
        tick();
        l_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n = 0;
        while (!radical_valid && n < budget) begin
            tick();
            n++;
        end
        ok = radical_valid;
    endtask

    task automatic take_result;
        radical_ready = 1'b1;
        tick();
        radical_ready = 1'b0;
    endtask

    task automatic run_column(input logic [RAD_W-1:0] d, input int k, input logic [L_W-1:0] ls[$],
                              input int max_gap, output logic [RAD_W-1:0] r, output logic c,
                              output bit ok);
        bit bok;
        int n = (k > 32) ? 32 : k;
        ok = 1'b1;
        do_start(d, k);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_beat(ls[i], bok);
            ok &= bok;
        end
        wait_valid(20, bok);
        ok &= bok;
        repeat ($urandom_range(3, 0)) tick();
        r = radical;
        c = clamp;
        take_result();
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; diag_in = '0; k_len = '0;
        l_valid = 1'b0; l_data = '0; radical_ready = 1'b0;
        tick(); tick();
        checks++; if (radical_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", radical_valid); end
        checks++; if (radical !== '0) begin errors++; $display("FAIL reset_radical got %h want 0", radical); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL reset_l_ready got %b want 0", l_ready); end
        checks++; if (clamp !== 1'b0) begin errors++; $display("FAIL reset_clamp got %b want 0", clamp); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] er;
        logic ec;
        bit ok;
        ls = '{27'h10000};
        model(36'h40000, 1, ls, er, ec);
        do_start(36'h40000, 1);
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL single_l_ready got %b want 1", l_ready); end
        send_beat(ls[0], ok);
        tick(); tick();
        checks++; if (radical_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0 after edge 3", radical_valid); end
        tick();
        checks++; if (radical_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1 after edge 4", radical_valid); end
        checks++; if (radical !== er || clamp !== ec) begin errors++; $display("FAIL single_radical got %h/%b want %h/%b", radical, clamp, er, ec); end
        take_result();
        checks++; if (radical_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_return got v%b b%b want 0 0", radical_valid, busy); end
    endtask

    task automatic test_zero_len;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] er;
        logic ec;
        bit seen_ready;
        model(36'h90000, 0, ls, er, ec);
        do_start(36'h90000, 0);
        seen_ready = l_ready;
        checks++; if (radical_valid !== 1'b0) begin errors++; $display("FAIL zero_early got %b want 0 after edge 1", radical_valid); end
        tick();
        seen_ready |= l_ready;
        checks++; if (radical_valid !== 1'b1) begin errors++; $display("FAIL zero_latency got %b want 1 after edge 2", radical_valid); end
        checks++; if (radical !== er) begin errors++; $display("FAIL zero_radical got %h want %h", radical, er); end
        take_result();
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL zero_l_ready got %b want 0", seen_ready); end
    endtask

    task automatic test_gaps;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] er;
        logic ec;
        bit ok, ok2;
        ls = '{27'h7FE8000, 27'h0008000};
        model(36'h50000, 2, ls, er, ec);
        do_start(36'h50000, 2);
        send_beat(ls[0], ok);
        repeat (3) tick();
        send_beat(ls[1], ok2);
        ok &= ok2;
        wait_valid(10, ok2);
        ok &= ok2;
        checks++; if (!ok) begin errors++; $display("FAIL gaps_timeout got 0 want 1"); end
        checks++; if (radical !== er || clamp !== ec) begin errors++; $display("FAIL gaps_radical got %h/%b want %h/%b", radical, clamp, er, ec); end
        take_result();
    endtask

    task automatic test_negative;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] er, r;
        logic ec, c;
        bit ok;
        ls = '{27'h20000};
        model(36'h10000, 1, ls, er, ec);
        run_column(36'h10000, 1, ls, 0, r, c, ok);
        checks++; if (!ok || r !== er || c !== ec) begin errors++; $display("FAIL negative got %h/%b ok%b want %h/%b", r, c, ok, er, ec); end
    endtask

    task automatic test_backpressure;
        logic [L_W-1:0] ls[$];
        logic [L_W-1:0] none[$];
        logic [RAD_W-1:0] er, r;
        logic ec, c;
        bit ok;
        ls = '{27'h10000};
        model(36'h40000, 1, ls, er, ec);
        do_start(36'h40000, 1);
        send_beat(ls[0], ok);
        wait_valid(10, ok);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; diag_in = 36'h12345; k_len = '0;
            end
            tick();
            start = 1'b0;
            checks++; if (radical_valid !== 1'b1 || radical !== er || clamp !== ec) begin
                errors++; $display("FAIL hold_%0d got v%b %h/%b want 1 %h/%b", i, radical_valid, radical, clamp, er, ec);
            end
        end
        start = 1'b1; radical_ready = 1'b1;
        tick();
        start = 1'b0; radical_ready = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || radical_valid !== 1'b0) begin errors++; $display("FAIL start_in_out got b%b v%b want 0 0", busy, radical_valid); end
        model(36'h90000, 0, none, er, ec);
        run_column(36'h90000, 0, none, 0, r, c, ok);
        checks++; if (!ok || r !== er) begin errors++; $display("FAIL after_hold got %h ok%b want %h", r, ok, er); end
    endtask

    task automatic test_back_to_back;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] er;
        logic ec;
        int edges;
        int k = 5;
        for (int i = 0; i < k; i++) ls.push_back(L_W'($urandom));
        model(36'hF_0000_0000, k, ls, er, ec);
        radical_ready = 1'b1;
        do_start(36'hF_0000_0000, k);
        edges = 0;
        for (int i = 0; i < k; i++) begin
            checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, l_ready); end
            l_valid = 1'b1; l_data = ls[i];
            tick();
            edges++;
        end
        l_valid = 1'b0;
        while (!radical_valid && edges < 30) begin
            tick();
            edges++;
        end
        checks++; if (edges !== k + 3) begin errors++; $display("FAIL b2b_latency got %0d want %0d", edges, k + 3); end
        checks++; if (radical !== er || clamp !== ec) begin errors++; $display("FAIL b2b_radical got %h/%b want %h/%b", radical, clamp, er, ec); end
        tick();
        radical_ready = 1'b0;
        checks++; if (busy !== 1'b0 || radical_valid !== 1'b0) begin errors++; $display("FAIL b2b_turnaround got b%b v%b want 0 0", busy, radical_valid); end
        do_start(36'h1000, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", busy); end
        tick();
        take_result();
    endtask

    task automatic test_reset_mid;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] er, r;
        logic ec, c;
        bit ok;
        do_start(36'h77777, 4);
        send_beat(27'h1234, ok);
        send_beat(27'h5678, ok);
        reset = 1'b1;
        #1;
        checks++; if (radical_valid !== 1'b0 || radical !== '0 || clamp !== 1'b0 || l_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v%b r%h c%b lr%b b%b want all 0", radical_valid, radical, clamp, l_ready, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        ls = '{27'h10000};
        model(36'h40000, 1, ls, er, ec);
        run_column(36'h40000, 1, ls, 0, r, c, ok);
        checks++; if (!ok || r !== er || c !== ec) begin errors++; $display("FAIL post_reset got %h/%b ok%b want %h/%b", r, c, ok, er, ec); end
    endtask

    task automatic test_random;
        logic [L_W-1:0] ls[$];
        logic [RAD_W-1:0] d, er, r;
        logic ec, c;
        int k;
        bit ok;
        for (int n = 0; n < 25; n++) begin
            ls.delete();
            k = (n % 6 == 5) ? int'($urandom_range(40, 33)) : int'($urandom_range(32, 0));
            for (int i = 0; i < 32; i++) ls.push_back(L_W'($urandom));
            d = (n % 2 == 0) ? RAD_W'({$urandom, $urandom}) : RAD_W'($urandom_range(32'h3FFFF, 0));
            model(d, k, ls, er, ec);
            run_column(d, k, ls, 2, r, c, ok);
            checks++; if (!ok || r !== er || c !== ec) begin
                errors++; $display("FAIL random_%0d k%0d got %h/%b ok%b want %h/%b", n, k, r, c, ok, er, ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_gaps();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
